// File: rtl/cpu_pkg.sv
// Shared types and defaults for the program counter / fetch sequencer.
`default_nettype none

package cpu_pkg;

  localparam int unsigned DEF_IW         = 16;
  localparam int unsigned DEF_CW         = 16;
  localparam int unsigned DEF_START_ADDR = 0;

  typedef logic [DEF_IW-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_counter_fetch_if.sv
// Control/redirect inputs and fetch status outputs of the fetch sequencer.
`default_nettype none

interface prog_counter_fetch_if #(
  parameter int unsigned IW = 16,
  parameter int unsigned CW = 16
);

  logic          Start;
  logic          Stall;
  logic          BranchEn;
  logic          BranchRel;
  logic [IW-1:0] BranchTarget;
  logic          Halt;
  logic [IW-1:0] InstAddress;
  logic          Running;
  logic          Done;
  logic [CW-1:0] InstCount;

  modport master (
    output Start, Stall, BranchEn, BranchRel, BranchTarget, Halt,
    input  InstAddress, Running, Done, InstCount
  );

  modport slave (
    input  Start, Stall, BranchEn, BranchRel, BranchTarget, Halt,
    output InstAddress, Running, Done, InstCount
  );

endinterface

`default_nettype wire

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential increment, absolute or PC-relative branch.
`default_nettype none

module next_pc_calc #(
  parameter int unsigned IW = 16
) (
  input  logic [IW-1:0] pc,
  input  logic          branch_en,
  input  logic          branch_rel,
  input  logic [IW-1:0] branch_target,
  output logic [IW-1:0] next_pc
);

  // Offset is already IW bits wide, so sign extension is implicit and the sum wraps mod 2**IW.
  always_comb begin
    next_pc = pc + IW'(1);
    if (branch_en) begin
      next_pc = branch_rel ? (pc + branch_target) : branch_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_counter_fetch.sv
// Program counter and fetch sequencer driving the instruction ROM address, with run/halt control.
`default_nettype none

module prog_counter_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned IW         = DEF_IW,
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned START_ADDR = DEF_START_ADDR
) (
  input  logic               CLK,
  input  logic               Reset_n,
  prog_counter_fetch_if.slave bus
);

  localparam logic [IW-1:0] START_PC = IW'(START_ADDR);

  fetch_state_t  state, state_nxt;
  logic [IW-1:0] pc, pc_nxt, pc_seq;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;

  next_pc_calc #(.IW(IW)) u_next_pc (
    .pc            (pc),
    .branch_en     (bus.BranchEn),
    .branch_rel    (bus.BranchRel),
    .branch_target (bus.BranchTarget),
    .next_pc       (pc_seq)
  );

  // Count saturates at all-ones rather than wrapping.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc    <= START_PC;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    case (state)
      IDLE, HALTED: begin
        if (bus.Start) begin
          state_nxt = RUN;
          pc_nxt    = START_PC;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (bus.Start) begin
          pc_nxt  = START_PC;
          cnt_nxt = '0;
        end else if (bus.Stall) begin
          pc_nxt  = pc;
        end else if (bus.Halt) begin
          state_nxt = HALTED;
          cnt_nxt   = cnt_inc;
        end else begin
          pc_nxt  = pc_seq;
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.InstAddress = pc;
  assign bus.Running     = (state == RUN);
  assign bus.Done        = (state == HALTED);
  assign bus.InstCount   = cnt;

endmodule

`default_nettype wire
